// File: rtl/aqfp_pkg.sv
// logicAQFP sample encoding shared by the readout deserializer.
// Two-bit quaternary values; bit 1 flags a non-binary state.
package aqfp_pkg;
  typedef logic [1:0] aqfp_t;

  localparam aqfp_t Q0 = 2'b00;
  localparam aqfp_t Q1 = 2'b01;
  localparam aqfp_t QX = 2'b10;
  localparam aqfp_t QZ = 2'b11;

  function automatic logic is_bad(aqfp_t s);
    return s[1];
  endfunction
endpackage

// File: rtl/aqfp_rdo_fifo.sv
// Power-of-two word FIFO for assembled readout words.
// Push into a full FIFO is accepted only if a pop frees the slot.
module aqfp_rdo_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                   clkin,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = level == (AW+1)'(DEPTH);
  assign empty   = level == '0;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/aqfp_readout_deser.sv
// AQFP readout deserializer: packs sampled bits into words
// tagged with an error flag and queues them for a consumer.
module aqfp_readout_deser
  import aqfp_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clkin,
  input  logic                   rst_n,
  input  logic                   smp_en,
  input  logic [1:0]             din,
  input  logic                   clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_W-1:0]      out_data,
  output logic                   out_err,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);
  localparam int CW = $clog2(WORD_W);
  localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);

  logic [CW-1:0]     bit_cnt;
  logic [WORD_W-1:0] asm_q;
  logic [WORD_W-1:0] asm_nx;
  logic              err_q;
  logic              err_nx;
  logic              last;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [WORD_W:0]   head;
  logic [WORD_W:0]   hold_q;

  always_comb begin
    asm_nx          = asm_q;
    asm_nx[bit_cnt] = (din == Q1);
    err_nx          = err_q | is_bad(din);
  end

  assign last      = bit_cnt == LAST;
  assign push      = smp_en & last & ~clr;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready & ~clr;

  aqfp_rdo_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clkin (clkin),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .wdata ({err_nx, asm_nx}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      asm_q    <= '0;
      err_q    <= 1'b0;
      overflow <= 1'b0;
    end else if (clr) begin
      bit_cnt  <= '0;
      asm_q    <= '0;
      err_q    <= 1'b0;
      overflow <= 1'b0;
    end else if (smp_en) begin
      if (last) begin
        bit_cnt <= '0;
        asm_q   <= '0;
        err_q   <= 1'b0;
        if (full && !pop) overflow <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
        asm_q   <= asm_nx;
        err_q   <= err_nx;
      end
    end
  end

  // Keeps the last shown head so outputs hold while empty.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n)     hold_q <= '0;
    else if (!empty) hold_q <= head;
  end

  assign {out_err, out_data} = empty ? hold_q : head;
endmodule

// File: tb/tb_aqfp_readout_deser.sv
// Directed and random checks of aqfp_readout_deser against
// a queue-based word model.
module tb_aqfp_readout_deser;
  import aqfp_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  logic       clkin = 1'b0;
  logic       rst_n;
  logic       smp_en = 1'b0;
  logic [1:0] din = Q0;
  logic       clr = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [W-1:0] out_data;
  logic       out_err;
  logic       overflow;
  logic [$clog2(D):0] level;

  int tests = 0;
  int fails = 0;

  logic [W:0] q[$];
  bit         bits[$];
  bit         merr;
  bit         movf;
  logic [W:0] mlast;

  always #5 clkin = ~clkin;

  aqfp_readout_deser #(.WORD_W(W), .DEPTH(D)) dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .smp_en    (smp_en),
    .din       (din),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .overflow  (overflow),
    .level     (level)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [W:0] h;
    h = (q.size() != 0) ? q[0] : mlast;
    chk("valid", 32'(out_valid), 32'(q.size() != 0));
    chk("level", 32'(level), 32'(q.size()));
    chk("ovf", 32'(overflow), 32'(movf));
    chk("data", 32'(out_data), 32'(h[W-1:0]));
    chk("err", 32'(out_err), 32'(h[W]));
  endtask

  task automatic model_step(input bit smp, input logic [1:0] d,
                            input bit rdy, input bit c);
    bit popped;
    bit full_pre;
    logic [W-1:0] w;
    if (q.size() != 0) mlast = q[0];
    if (c) begin
      q.delete();
      bits.delete();
      merr = 0;
      movf = 0;
      return;
    end
    popped   = rdy && (q.size() != 0);
    full_pre = (q.size() == D);
    if (popped) void'(q.pop_front());
    if (smp) begin
      bits.push_back(d == Q1);
      merr = merr | d[1];
      if (bits.size() == W) begin
        w = '0;
        foreach (bits[i]) if (bits[i]) w = w | (W'(1) << i);
        if (full_pre && !popped) movf = 1;
        else q.push_back({merr, w});
        bits.delete();
        merr = 0;
      end
    end
  endtask

  task automatic step(input bit smp, input logic [1:0] d,
                      input bit rdy, input bit c);
    @(negedge clkin);
    smp_en    = smp;
    din       = d;
    out_ready = rdy;
    clr       = c;
    model_step(smp, d, rdy, c);
    @(posedge clkin);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clkin);
    rst_n = 1'b0;
    smp_en = 1'b0;
    clr = 1'b0;
    q.delete();
    bits.delete();
    merr = 0;
    movf = 0;
    mlast = '0;
    #1;
    check_all();
    repeat (2) @(negedge clkin);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [W-1:0] bv,
                      input logic [W-1:0] bad,
                      input bit rdy, input bit rdy_last,
                      input bit clr_last);
    logic [1:0] d;
    for (int i = 0; i < W; i++) begin
      if (bad[i]) d = ($urandom_range(0, 1) != 0) ? QZ : QX;
      else d = bv[i] ? Q1 : Q0;
      if (i == W - 1) step(1, d, rdy_last, clr_last);
      else step(1, d, rdy, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    mlast = '0;
    merr = 0;
    movf = 0;
    do_reset();

    send(8'h8D, 8'h00, 1, 1, 0);
    chk("w1_valid", 32'(out_valid), 32'd1);
    chk("w1_data", 32'(out_data), 32'h8D);
    chk("w1_err", 32'(out_err), 32'd0);
    step(0, Q0, 1, 0);
    chk("w1_pulse", 32'(out_valid), 32'd0);
    chk("w1_hold", 32'(out_data), 32'h8D);

    send(8'h8D, 8'h08, 1, 1, 0);
    chk("w2_data", 32'(out_data), 32'h85);
    chk("w2_err", 32'(out_err), 32'd1);
    step(0, Q0, 1, 0);
    send(8'h3C, 8'h00, 1, 1, 0);
    chk("w3_err", 32'(out_err), 32'd0);
    step(0, Q0, 1, 0);

    repeat (5) send(8'hFF, 8'h00, 0, 0, 0);
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_ff", 32'(out_data), 32'hFF);
      step(0, Q0, 1, 0);
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    step(0, Q0, 0, 1);
    chk("clr_ovf", 32'(overflow), 32'd0);
    repeat (4) send(W'($urandom), 8'h00, 0, 0, 0);
    send(W'($urandom), 8'h00, 0, 1, 0);
    chk("fp_level", 32'(level), 32'd4);
    chk("fp_ovf", 32'(overflow), 32'd0);
    repeat (5) step(0, Q0, 1, 0);
    chk("fp_empty", 32'(out_valid), 32'd0);

    for (int i = 0; i < 5; i++) step(1, Q1, 0, 0);
    do_reset();
    chk("rst_level", 32'(level), 32'd0);
    send(8'h00, 8'h00, 0, 0, 0);
    chk("rw_level", 32'(level), 32'd1);
    chk("rw_data", 32'(out_data), 32'h00);
    chk("rw_err", 32'(out_err), 32'd0);
    step(0, Q0, 1, 0);
    chk("rw_one", 32'(out_valid), 32'd0);

    send(8'h11, 8'h00, 0, 0, 0);
    send(8'h22, 8'h00, 0, 0, 0);
    chk("cl_pre", 32'(level), 32'd2);
    send(8'hA5, 8'h00, 0, 0, 1);
    chk("cl_level", 32'(level), 32'd0);
    send(8'h01, 8'h00, 1, 1, 0);
    chk("cl_bit0", 32'(out_data), 32'h01);
    step(0, Q0, 1, 0);

    for (int i = 0; i < 3; i++) step(1, Q1, 0, 0);
    repeat (40) step(0, Q0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, Q0, 0, 0);
    chk("gap_data", 32'(out_data), 32'h07);

    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 1) != 0),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/aqfp_readout_deser.md
AQFP_READOUT_DESER -- requirements
Module: aqfp_readout_deser

Interface
REQ-001 Parameter WORD_W, default 8: bits per assembled output word, legal range 2..32.
REQ-002 Parameter DEPTH, default 4: output FIFO entries, power of two, range 2..16.
REQ-003 Port clkin, input, 1: the single block clock, rising-edge active.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port smp_en, input, 1: high for one cycle at each AQFP sampling point; din is valid only in that cycle.
REQ-006 Port din, input, 2: logicAQFP sample, encoded as q0=2'b00, q1=2'b01, qX=2'b10, qZ=2'b11.
REQ-007 Port clr, input, 1: synchronous clear of the partial word, the FIFO and the sticky flags.
REQ-008 Port out_valid, output, 1: FIFO head holds a word.
REQ-009 Port out_ready, input, 1: consumer accepts the head word when out_valid and out_ready are both high.
REQ-010 Port out_data, output, WORD_W: head word, with bit 0 being the first sample received.
REQ-011 Port out_err, output, 1: head word contained at least one qX or qZ sample.
REQ-012 Port overflow, output, 1: sticky, a completed word was dropped.
REQ-013 Port level, output, $clog2(DEPTH)+1: current FIFO occupancy.

Function
REQ-014 Each smp_en cycle shall shift one bit into the assembly register at index bit_cnt: q1 gives 1; q0, qX and qZ give 0.
REQ-015 A qX or qZ sample shall set the word-error flag of the word in assembly.
REQ-016 bit_cnt shall count 0..WORD_W-1 and wrap to 0 on the sample that completes a word.
REQ-017 The completing sample shall push {err, word} into the FIFO at the same clock edge that shifts it in; out_valid shall rise on the next cycle if the FIFO was empty (latency 1 cycle).
REQ-018 The assembly error flag shall clear when a word completes, whether that word is pushed or dropped.
REQ-019 A pop shall occur when out_valid and out_ready are both high; the head shall advance at that edge.
REQ-020 Full FIFO on a push with no pop in the same cycle: drop the word, set overflow, leave the FIFO contents unchanged.
REQ-021 Full FIFO on a push with a pop in the same cycle: accept both operations; level stays at DEPTH; overflow is not set.
REQ-022 Empty FIFO: out_valid=0; out_data and out_err shall hold their last values; out_ready is ignored.
REQ-023 Simultaneous push and pop on a non-full FIFO shall leave level unchanged.
REQ-024 Pointers shall wrap modulo DEPTH.
REQ-025 clr shall take priority over smp_en and any pop in the same cycle: bit_cnt=0, FIFO empty, overflow=0, assembly error flag=0.
REQ-026 smp_en low shall leave the assembly state unchanged, including across arbitrarily long gaps.

Reset
REQ-027 Assertion of rst_n=0 shall immediately force: out_valid=0, out_data=0, out_err=0, overflow=0, level=0, bit_cnt=0, assembly register=0, and both pointers to 0.
REQ-028 Reset mid-word shall discard the partial word with no push.
REQ-029 The first smp_en after deassertion shall be treated as bit 0.

Structure
REQ-030 The logicAQFP encoding constants and the 2-bit typedef shall live in the shared package aqfp_pkg.
REQ-031 The storage shall be the sub-module aqfp_rdo_fifo (parameters WIDTH=WORD_W+1 and DEPTH), with ports for push, pop, full, empty and level.
REQ-032 The block shall contain no latches and no internally generated clocks.

Verification
REQ-033 WORD_W=8; samples q1,q0,q1,q1,q0,q0,q0,q1; out_ready=1 -> one cycle after the 8th sample: out_data=8'h8D, out_err=0, out_valid pulses for one cycle.
REQ-034 Same sequence with sample 3 replaced by qZ -> out_data=8'h85, out_err=1; the next clean word has out_err=0.
REQ-035 DEPTH=4, out_ready=0, five all-q1 words -> level=4, overflow=1; draining yields four words of 8'hFF; then out_valid=0.
REQ-036 FIFO full, out_ready=1 in the same cycle as the completing sample -> level stays 4, overflow stays 0, and output order is preserved.
REQ-037 Assert rst_n after 5 of 8 samples, then deassert and send 8 q0 samples -> exactly one word 8'h00 with out_err=0.
REQ-038 clr asserted in the same cycle as a completing smp_en with level=2 -> level=0, no word is pushed, and the next sample lands at bit 0.
